// File: rtl/cmps2_sampler.sv
// cmps2_sampler
//
// Measurement sequencer for the Pmod CMPS2 (MMC34160PJ) magnetometer. It sits
// directly in front of i2c_master and runs this loop: trigger a measurement,
// poll the status register until the measurement is done, then burst-read the
// six X/Y/Z bytes. Each good read is published as three signed 16-bit field
// samples together with a one-cycle valid strobe. Retries, poll timeouts and
// error accounting are all handled here, so downstream logic only ever sees
// complete, coherent samples.
//
// Parameters:
//   CLK_HZ          system clock frequency
//   SAMPLE_HZ       target measurement rate
//   DEV_ADDR        7-bit I2C address of the sensor
//   POLL_MAX        status reads allowed before the cycle is declared failed
//   STARTUP_CYCLES  sensor power-up delay after reset
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   enable                  run the sampling loop while high
//   start_txn               one-cycle request to i2c_master
//   device_addr, reg_addr   target device / register of the current transaction
//   rw, num_bytes, wr_data  direction (1 = read), byte count, write payload
//   rd_data, rd_valid       returned read bytes, one strobe per byte
//   busy, done, error       i2c_master status; error wins over done
//   mag_x, mag_y, mag_z     latest field sample (raw - 32768)
//   sample_valid            one-cycle pulse when mag_* update
//   sensor_err              last cycle failed; cleared by the next good sample
//   err_cnt                 saturating count of failed cycles

module cmps2_sampler #(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned SAMPLE_HZ      = 50,
  parameter logic [6:0]  DEV_ADDR       = 7'h30,
  parameter int unsigned POLL_MAX       = 16,
  parameter int unsigned STARTUP_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  output logic               start_txn,
  output logic [6:0]         device_addr,
  output logic [7:0]         reg_addr,
  output logic               rw,
  output logic [2:0]         num_bytes,
  output logic [7:0]         wr_data,
  input  logic [7:0]         rd_data,
  input  logic               rd_valid,
  input  logic               busy,
  input  logic               done,
  input  logic               error,
  output logic signed [15:0] mag_x,
  output logic signed [15:0] mag_y,
  output logic signed [15:0] mag_z,
  output logic               sample_valid,
  output logic               sensor_err,
  output logic [7:0]         err_cnt
);

  localparam int unsigned WaitCycles = CLK_HZ / SAMPLE_HZ - 1;

  localparam logic [7:0] RegData   = 8'h00;
  localparam logic [7:0] RegStatus = 8'h06;
  localparam logic [7:0] RegCtrl0  = 8'h07;
  localparam logic [7:0] CtrlTm    = 8'h01;  // take-measurement bit

  typedef enum logic [2:0] {
    StStartup,
    StIdle,
    StTrig,
    StPoll,
    StRead,
    StPublish,
    StWait
  } state_e;

  // Handshake phase of the transaction owned by the current state.
  typedef enum logic [1:0] {
    TxnNone,
    TxnSettle,  // fields just registered, give them a cycle before start
    TxnIssue,   // waiting for busy low to pulse start_txn
    TxnWait     // outstanding, waiting for done/error
  } txn_e;

  state_e state_q, state_d;
  txn_e   txn_q, txn_d;

  logic [31:0] cnt_q;
  logic [31:0] poll_cnt_q;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic        status_bit_q;
  logic [7:0]  shadow_q [6];
  logic [7:0]  shadow_d [6];

  logic [7:0]  reg_addr_q;
  logic        rw_q;
  logic [2:0]  num_bytes_q;
  logic [7:0]  wr_data_q;

  logic signed [15:0] mag_x_q, mag_y_q, mag_z_q;
  logic               sample_valid_q;
  logic               sensor_err_q;
  logic [7:0]         err_cnt_q;

  logic txn_end, txn_fail, txn_ok;
  logic status_ready;
  logic byte_cap;
  logic cycle_fail;
  logic poll_again;
  logic launch;

  // Sensor reports offset binary; flipping the MSB gives raw - 32768.
  function automatic logic [15:0] to_field(input logic [7:0] lo, input logic [7:0] hi);
    to_field = {~hi[7], hi[6:0], lo};
  endfunction

  // ---------------------------------------------------------------------------
  // Transaction status decode
  // ---------------------------------------------------------------------------
  assign txn_end  = (txn_q == TxnWait) && (done || error);
  assign txn_fail = (txn_q == TxnWait) && error;
  assign txn_ok   = txn_end && !error;

  // The status byte may arrive in the same cycle as done.
  assign status_ready = rd_valid ? rd_data[0] : status_bit_q;

  // Bytes past index 5 are dropped; index stops at 6.
  assign byte_cap   = (state_q == StRead) && (txn_q == TxnWait) && rd_valid &&
                      (byte_idx_q < 3'd6);
  assign byte_idx_d = byte_cap ? byte_idx_q + 3'd1 : byte_idx_q;

  always_comb begin
    shadow_d = shadow_q;
    if (byte_cap) begin
      shadow_d[byte_idx_q] = rd_data;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StStartup;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cycle_fail = 1'b0;
    poll_again = 1'b0;
    unique case (state_q)
      StStartup: begin
        if (cnt_q + 32'd1 >= STARTUP_CYCLES) state_d = StIdle;
      end
      StIdle: begin
        if (enable) state_d = StTrig;
      end
      StTrig: begin
        if (txn_fail) begin
          state_d    = StWait;
          cycle_fail = 1'b1;
        end else if (txn_ok) begin
          // With enable low the trigger write is allowed to finish, then we park.
          state_d = enable ? StPoll : StWait;
        end
      end
      StPoll: begin
        if (txn_fail) begin
          state_d    = StWait;
          cycle_fail = 1'b1;
        end else if (txn_ok) begin
          if (status_ready) begin
            state_d = enable ? StRead : StWait;
          end else if (poll_cnt_q + 32'd1 >= POLL_MAX) begin
            state_d    = StWait;
            cycle_fail = 1'b1;
          end else if (enable) begin
            poll_again = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StRead: begin
        if (txn_fail) begin
          state_d    = StWait;
          cycle_fail = 1'b1;
        end else if (txn_ok) begin
          if (byte_idx_d == 3'd6) begin
            state_d = StPublish;
          end else begin
            state_d    = StWait;
            cycle_fail = 1'b1;
          end
        end
      end
      StPublish: begin
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q + 32'd1 >= WaitCycles) state_d = enable ? StTrig : StIdle;
      end
      default: begin
        state_d = StStartup;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and handshake control
  // ---------------------------------------------------------------------------
  always_comb begin
    start_txn = (txn_q == TxnIssue) && !busy;
    launch    = poll_again ||
                ((state_d != state_q) &&
                 ((state_d == StTrig) || (state_d == StPoll) || (state_d == StRead)));

    txn_d = txn_q;
    if (launch) begin
      txn_d = TxnSettle;
    end else begin
      unique case (txn_q)
        TxnSettle: txn_d = TxnIssue;
        TxnIssue:  if (!busy) txn_d = TxnWait;
        TxnWait:   if (done || error) txn_d = TxnNone;
        default:   txn_d = TxnNone;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txn_q          <= TxnNone;
      cnt_q          <= '0;
      poll_cnt_q     <= '0;
      byte_idx_q     <= '0;
      status_bit_q   <= 1'b0;
      for (int i = 0; i < 6; i++) shadow_q[i] <= '0;
      reg_addr_q     <= '0;
      rw_q           <= 1'b0;
      num_bytes_q    <= 3'd1;
      wr_data_q      <= '0;
      mag_x_q        <= '0;
      mag_y_q        <= '0;
      mag_z_q        <= '0;
      sample_valid_q <= 1'b0;
      sensor_err_q   <= 1'b0;
      err_cnt_q      <= '0;
    end else begin
      txn_q      <= txn_d;
      shadow_q   <= shadow_d;
      byte_idx_q <= byte_idx_d;

      // Shared delay counter, restarted on every state change.
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if ((state_q == StStartup) || (state_q == StWait)) begin
        cnt_q <= cnt_q + 32'd1;
      end

      if ((state_q == StPoll) && (txn_q == TxnWait) && rd_valid) begin
        status_bit_q <= rd_data[0];
      end

      if ((state_q == StTrig) && (state_d == StPoll)) begin
        poll_cnt_q <= '0;
      end else if (poll_again) begin
        poll_cnt_q <= poll_cnt_q + 32'd1;
      end

      // Command fields change only here, so they hold for the whole transaction.
      if (launch) begin
        status_bit_q <= 1'b0;
        unique case (state_d)
          StTrig: begin
            reg_addr_q  <= RegCtrl0;
            rw_q        <= 1'b0;
            num_bytes_q <= 3'd1;
            wr_data_q   <= CtrlTm;
          end
          StPoll: begin
            reg_addr_q  <= RegStatus;
            rw_q        <= 1'b1;
            num_bytes_q <= 3'd1;
            wr_data_q   <= '0;
          end
          StRead: begin
            reg_addr_q  <= RegData;
            rw_q        <= 1'b1;
            num_bytes_q <= 3'd6;
            wr_data_q   <= '0;
            byte_idx_q  <= '0;
          end
          default: ;
        endcase
      end

      // Publishing from shadow_d lets a final byte coincident with done land.
      sample_valid_q <= (state_d == StPublish);
      if (state_d == StPublish) begin
        mag_x_q      <= to_field(shadow_d[0], shadow_d[1]);
        mag_y_q      <= to_field(shadow_d[2], shadow_d[3]);
        mag_z_q      <= to_field(shadow_d[4], shadow_d[5]);
        sensor_err_q <= 1'b0;
      end

      if (cycle_fail) begin
        sensor_err_q <= 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign device_addr  = DEV_ADDR;
  assign reg_addr     = reg_addr_q;
  assign rw           = rw_q;
  assign num_bytes    = num_bytes_q;
  assign wr_data      = wr_data_q;
  assign mag_x        = mag_x_q;
  assign mag_y        = mag_y_q;
  assign mag_z        = mag_z_q;
  assign sample_valid = sample_valid_q;
  assign sensor_err   = sensor_err_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: doc/cmps2_sampler.md
# cmps2_sampler

Measurement sequencer sitting directly upstream of `i2c_master` on the Pmod CMPS2 path. It issues the MMC34160PJ command sequence: trigger measurement, poll status, burst-read X/Y/Z. It assembles the six returned bytes into signed 16-bit field samples and presents them to the heading logic with a one-cycle valid strobe. It owns all retry, poll-timeout and error accounting, so the heading stage only ever sees complete, coherent samples.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, system clock frequency.
- `SAMPLE_HZ`, 50, target measurement rate.
- `DEV_ADDR`, 7'h30, sensor 7-bit I2C address.
- `POLL_MAX`, 16, status reads allowed before a poll timeout.
- `STARTUP_CYCLES`, 1_000_000, delay after reset before the first transaction (sensor power-up).

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `enable` in 1: run sampling loop while high.
- `start_txn` out 1: one-cycle request to `i2c_master`.
- `device_addr` out 7: always `DEV_ADDR`.
- `reg_addr` out 8: register for current transaction.
- `rw` out 1: 0 = write, 1 = read.
- `num_bytes` out 3: byte count for current transaction.
- `wr_data` out 8: write payload.
- `rd_data` in 8: byte from master.
- `rd_valid` in 1: `rd_data` valid strobe, one per byte.
- `busy` in 1: master busy.
- `done` in 1: transaction complete pulse.
- `error` in 1: transaction failed pulse (NACK).
- `mag_x`, `mag_y`, `mag_z` out 16 signed: latest field sample.
- `sample_valid` out 1: one-cycle pulse when `mag_*` update.
- `sensor_err` out 1: last cycle failed; clears on next good sample.
- `err_cnt` out 8: saturating count of failed cycles.

## Operation
- States: `STARTUP`, `IDLE`, `TRIG`, `POLL`, `READ`, `PUBLISH`, `WAIT`.
- `STARTUP`: count `STARTUP_CYCLES`, then go to `IDLE`.
- `IDLE`: wait for `enable` = 1, then go to `TRIG`.
- `TRIG`: write reg 0x07 = 0x01 (TM bit), `num_bytes`=1, `rw`=0. On `done` go to `POLL` with the poll count cleared.
- `POLL`: read reg 0x06, 1 byte.
  - On `done`: bit0 = 1 goes to `READ`.
  - Otherwise the poll count increments and the read is reissued.
  - After `POLL_MAX` reads without bit0 set, the cycle fails.
- `READ`: read reg 0x00, `num_bytes`=6.
  - Byte index 0..5 advances on each `rd_valid`. Bytes are X_L, X_H, Y_L, Y_H, Z_L, Z_H into shadow registers.
  - `rd_valid` beyond index 5 is ignored.
  - On `done` with index = 6, go to `PUBLISH`. `done` with index < 6 fails the cycle.
- `PUBLISH`: copy shadow registers to `mag_*`, pulse `sample_valid`, clear `sensor_err`, go to `WAIT`.
- Conversion: `mag_n` = {~raw[15], raw[14:0]}, i.e. raw − 32768. So 0x8000 maps to 0, 0xFFFF to +32767, and 0x0000 to −32768.
- Failed cycle (master `error`, poll timeout, short read):
  - Set `sensor_err`; increment `err_cnt`, saturating at 255.
  - Leave `mag_*` unchanged; go to `WAIT`.
- `WAIT`: count `CLK_HZ/SAMPLE_HZ − 1` cycles, then go to `TRIG` if `enable` = 1, else `IDLE`.
- `enable` low mid-cycle: the current transaction completes, then the block goes to `WAIT`, then `IDLE`. A transaction is never abandoned.

## Timing
- Reset values: `start_txn` 0, `device_addr` `DEV_ADDR`, `reg_addr` 0, `rw` 0, `num_bytes` 1, `wr_data` 0, `mag_*` 0, `sample_valid` 0, `sensor_err` 0, `err_cnt` 0. State goes to `STARTUP`.
- Transaction handshake:
  - Command fields are registered on state entry.
  - `start_txn` is asserted for exactly one cycle, on the first cycle with `busy` = 0 at least one cycle after the fields settle.
  - Fields are held stable until `done` or `error`.
  - No second `start_txn` is issued before `done` or `error` for the first.
- `done` and `error` in the same cycle: treated as error.
- `sample_valid` rises 1 cycle after the read's `done`. `mag_*` are stable from that cycle until the next `sample_valid`.
- Reset asserted mid-transaction: all outputs return to reset values on the next edge. `i2c_master` shares `rst_n` and aborts with it.

## Test plan
- Behavioral master: `done` 20 cycles after `start_txn`; status returns 0x01; read bytes 0x00,0x80,0xFF,0xFF,0x00,0x00 -> `sample_valid` once, `mag_x`=0, `mag_y`=+32767, `mag_z`=−32768; `sensor_err`=0.
- Status returns 0x00 three times, then 0x01 -> exactly 4 status reads (reg 0x06), then one 6-byte read of reg 0x00; sample published.
- Status stays 0x00 -> exactly `POLL_MAX` reads, no `sample_valid`, `sensor_err`=1, `err_cnt`=1. The next good cycle clears `sensor_err`; `err_cnt` stays 1.
- Master `error` on the TRIG write, repeated 300 cycles -> `err_cnt` saturates at 255, `mag_*` keep their prior values, never more than one outstanding `start_txn`.
- `enable` dropped during READ -> the read completes and publishes, then no further `start_txn` after `WAIT`. Re-enable -> next cycle starts with a 0x07 write.
- With `SAMPLE_HZ`=50, `CLK_HZ`=100e6 -> consecutive `sample_valid` spaced by 2,000,000 cycles plus the transaction time. `rst_n` low mid-READ -> all outputs at reset values on the next edge.
